// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, encoder helpers and loader state type.
// Used by instr_encode and instr_encoder_loader.
package mips_pkg;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_J   = 4'd9;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } ld_state_t;

    function automatic logic [31:0] enc_r(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] fn
    );
        return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational descriptor-to-MIPS-word encoder.
// Unknown op types yield word 0 with illegal asserted.
module instr_encode
    import mips_pkg::*;
(
    input  logic [3:0]  op_type,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        unique case (op_type)
            OP_ADD:  word = enc_r(rs, rt, rd, FN_ADD);
            OP_SUB:  word = enc_r(rs, rt, rd, FN_SUB);
            OP_AND:  word = enc_r(rs, rt, rd, FN_AND);
            OP_OR:   word = enc_r(rs, rt, rd, FN_OR);
            OP_SLT:  word = enc_r(rs, rt, rd, FN_SLT);
            OP_LW:   word = enc_i(OPC_LW, rs, rt, imm);
            OP_SW:   word = enc_i(OPC_SW, rs, rt, imm);
            OP_BEQ:  word = enc_i(OPC_BEQ, rs, rt, imm);
            OP_J:    word = {OPC_J, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams op descriptors into instruction memory as MIPS words.
// Define ENC_ILLEGAL_TRAP_EN to abort a session on an illegal op.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op_type,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

`ifdef ENC_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    ld_state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word_q;
    logic              last_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        hs;
    logic        trap;
    logic        ack;

    instr_encode u_enc (
        .op_type (in_op_type),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign hs   = in_valid && (state == ST_ACCEPT);
    assign trap = TRAP_EN & enc_illegal;
    assign ack  = mem_ack && (state == ST_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_n = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_n = trap ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (mem_ack) state_n = last_q ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                addr_q  <= base_addr;
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (hs) begin
                if (trap) begin
                    err_q <= 1'b1;
                end else begin
                    word_q <= enc_word;
                    last_q <= in_last;
                end
            end
            if (ack) begin
                addr_q <= addr_q + 1'b1;
                if (count_q != '1) count_q <= count_q + 1'b1;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed vector bench for instr_encoder_loader (ADDR_W=8).
// Illegal-op expectations follow ENC_ILLEGAL_TRAP_EN.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op_type = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [8:0]  count;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op_type (in_op_type),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .err        (err)
    );

    typedef struct {
        logic [7:0]  base;
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic [7:0]  base,
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] tgt,
        input logic        last,
        input logic [31:0] exp
    );
        vec_t v;
        v.base = base; v.op = op;
        v.rs = rs; v.rt = rt; v.rd = rd;
        v.imm = imm; v.tgt = tgt;
        v.last = last; v.exp = exp;
        return v;
    endfunction

    task automatic check(
        input string       name,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_count", 32'(count), 0);
        check("start_err", 32'(err), 0);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !in_ready; k++)
            @(negedge clk);
        check("ready_to", 32'(in_ready), 1);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op_type = v.op;
        in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
        in_imm = v.imm; in_target = v.tgt;
        in_last = v.last;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic [7:0] a);
        wait_ready();
        drive(v);
        check("we", 32'(mem_we), 1);
        check("addr", 32'(mem_addr), 32'(a));
        check("wdata", mem_wdata, v.exp);
        check("rdy_wr", 32'(in_ready), 0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic end_session(input int n);
        check("done", 32'(done), 1);
        check("we_done", 32'(mem_we), 0);
        check("count", 32'(count), 32'(n));
        @(negedge clk);
        check("done_1cyc", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("count_hold", 32'(count), 32'(n));
    endtask

    initial begin
        logic [7:0] a;
        int n;
        vec_t v;

        tbl[0]  = mk(8'h10, 4'd1, 5'd1, 5'd2, 5'd3, 16'h5A5A, 26'h2AAAAAA, 0, 32'h00221820);
        tbl[1]  = mk(8'h10, 4'd6, 5'd4, 5'd5, 5'd7, 16'h0008, 26'h2AAAAAA, 0, 32'h8C850008);
        tbl[2]  = mk(8'h10, 4'd9, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0000040, 1, 32'h08000040);
        tbl[3]  = mk(8'h40, 4'd2, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h2AAAAAA, 0, 32'h00221822);
        tbl[4]  = mk(8'h40, 4'd3, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h2AAAAAA, 0, 32'h00853024);
        tbl[5]  = mk(8'h40, 4'd4, 5'd7, 5'd8, 5'd9, 16'hFFFF, 26'h2AAAAAA, 0, 32'h00E84825);
        tbl[6]  = mk(8'h40, 4'd5, 5'd31, 5'd30, 5'd29, 16'hFFFF, 26'h2AAAAAA, 0, 32'h03FEE82A);
        tbl[7]  = mk(8'h40, 4'd7, 5'd29, 5'd31, 5'd3, 16'hFFFC, 26'h2AAAAAA, 0, 32'hAFBFFFFC);
        tbl[8]  = mk(8'h40, 4'd8, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h2AAAAAA, 0, 32'h1022FFFF);
        tbl[9]  = mk(8'h40, 4'd9, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FFFFFF, 1, 32'h0BFFFFFF);
        tbl[10] = mk(8'hFF, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0000000, 0, 32'h00221820);
        tbl[11] = mk(8'hFF, 4'd7, 5'd4, 5'd5, 5'd0, 16'h0008, 26'h0000000, 1, 32'hAC850008);

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // table sessions: 0x10 x3, 0x40 x7, 0xFF wrap x2
        a = '0;
        n = 0;
        for (int i = 0; i < NV; i++) begin
            if (i == 0 || tbl[i-1].last) begin
                do_start(tbl[i].base);
                a = tbl[i].base;
                n = 0;
            end
            send(tbl[i], a);
            a = a + 8'd1;
            n++;
            if (tbl[i].last) end_session(n);
        end

        // stalled sw write
        do_start(8'h20);
        wait_ready();
        drive(mk(8'h20, 4'd7, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 1, 32'h0));
        for (int k = 0; k < 4; k++) begin
            check("stall_we", 32'(mem_we), 1);
            check("stall_addr", 32'(mem_addr), 32'h20);
            check("stall_wdata", mem_wdata, 32'hAC430010);
            check("stall_rdy", 32'(in_ready), 0);
            @(negedge clk);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        end_session(1);

        // illegal op mid-session
        do_start(8'h30);
        send(tbl[0], 8'h30);
        v = mk(8'h30, 4'd12, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 0, 32'h0);
`ifdef ENC_ILLEGAL_TRAP_EN
        wait_ready();
        drive(v);
        check("trap_we", 32'(mem_we), 0);
        check("trap_err", 32'(err), 1);
        end_session(1);
        check("trap_err_hold", 32'(err), 1);
        check("trap_rdy", 32'(in_ready), 0);
`else
        send(v, 8'h31);
        check("nop_err", 32'(err), 0);
        v = tbl[0];
        v.last = 1'b1;
        send(v, 8'h32);
        end_session(3);
        check("nop_err_end", 32'(err), 0);
`endif

        // start while busy is ignored
        do_start(8'h70);
        send(tbl[0], 8'h70);
        start = 1'b1;
        base_addr = 8'h00;
        v = tbl[1];
        v.last = 1'b1;
        send(v, 8'h71);
        start = 1'b0;
        end_session(2);

        // async reset during a write
        do_start(8'h50);
        wait_ready();
        drive(tbl[3]);
        check("pre_rst_we", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        check("arst_we", 32'(mem_we), 0);
        check("arst_addr", 32'(mem_addr), 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_count", 32'(count), 0);
        check("arst_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(8'h60);
        send(tbl[2], 8'h60);
        end_session(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
